// File: rtl/vth_level_detector.sv
// Hard-decision read detector: slices voltages into 2-bit levels, checks them against queued written
// levels and accumulates symbol/Gray-bit error counts over a fixed-length run. 1-cycle latency, no backpressure.

module vth_level_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdat;
    end
endmodule

module vth_level_detector #(
    parameter int VW        = 16,
    parameter int CNT_W     = 32,
    parameter int DEPTH     = 16,
    parameter int N_SAMPLES = 327600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VW-1:0]    thr0,
    input  logic [VW-1:0]    thr1,
    input  logic [VW-1:0]    thr2,
    input  logic             wr_valid,
    input  logic [1:0]       wr_level,
    input  logic             rd_valid,
    input  logic [VW-1:0]    rd_voltage,
    output logic             det_valid,
    output logic [1:0]       det_level,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             underflow
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [63:0] N_TARGET = 64'(N_SAMPLES);

    state_t         state;
    state_t         state_nxt;
    logic           clear;
    logic           run;
    logic           wr_en;
    logic           rd_en;
    logic           count_ev;
    logic           hit;
    logic [1:0]     lvl_dec;
    logic [1:0]     ref_level;
    logic [1:0]     gray_x;
    logic [1:0]     bit_errs;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CNT_W-1:0] sample_inc;
    logic [CNT_W-1:0] sym_nxt;
    logic [CNT_W:0]   bit_sum;
    logic [CNT_W-1:0] bit_nxt;

    function automatic logic [1:0] gray(input logic [1:0] l);
        return {l[1], l[1] ^ l[0]};
    endfunction

    assign run      = (state == S_RUN);
    assign busy     = run;
    assign done     = (state == S_DONE);
    assign wr_en    = run && wr_valid;
    assign rd_en    = run && rd_valid;
    assign count_ev = rd_en && !fifo_empty;

    // Priority chain keeps a defined answer even when thresholds are not monotone.
    always_comb begin
        lvl_dec = 2'd3;
        if (rd_voltage < thr0)      lvl_dec = 2'd0;
        else if (rd_voltage < thr1) lvl_dec = 2'd1;
        else if (rd_voltage < thr2) lvl_dec = 2'd2;
    end

    vth_level_fifo #(.W(2), .DEPTH(DEPTH)) u_ref_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (wr_en),
        .pop   (rd_en),
        .wdat  (wr_level),
        .rdat  (ref_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign gray_x     = gray(lvl_dec) ^ gray(ref_level);
    assign bit_errs   = {1'b0, gray_x[0]} + {1'b0, gray_x[1]};
    assign sample_inc = (&sample_cnt) ? sample_cnt : sample_cnt + 1'b1;
    assign sym_nxt    = ((lvl_dec != ref_level) && !(&sym_err_cnt)) ? sym_err_cnt + 1'b1 : sym_err_cnt;
    assign bit_sum    = {1'b0, bit_err_cnt} + (CNT_W+1)'(bit_errs);
    assign bit_nxt    = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    assign hit        = (64'(sample_inc) == N_TARGET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (count_ev && hit) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_valid   <= 1'b0;
            det_level   <= '0;
            sample_cnt  <= '0;
            sym_err_cnt <= '0;
            bit_err_cnt <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            det_valid <= rd_en;
            if (rd_en) det_level <= lvl_dec;
            if (clear) begin
                sample_cnt  <= '0;
                sym_err_cnt <= '0;
                bit_err_cnt <= '0;
                overflow    <= 1'b0;
                underflow   <= 1'b0;
            end else begin
                if (count_ev) begin
                    sample_cnt  <= sample_inc;
                    sym_err_cnt <= sym_nxt;
                    bit_err_cnt <= bit_nxt;
                end
                if (wr_en && fifo_full && !rd_en) overflow <= 1'b1;
                if (rd_en && fifo_empty)          underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vth_level_detector.sv
// Scoreboarded bench: unit A (DEPTH=4, N_SAMPLES=8) covers slicing, errors, FIFO limits, run end and reset;
// unit B (CNT_W=4) covers counter saturation.
module tb_vth_level_detector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] thr0 = 16'd1000;
    logic [15:0] thr1 = 16'd2000;
    logic [15:0] thr2 = 16'd3000;

    logic        a_start = 0, a_wr_valid = 0, a_rd_valid = 0;
    logic [1:0]  a_wr_level = 0;
    logic [15:0] a_rd_voltage = 0;
    logic        a_det_valid, a_busy, a_done, a_overflow, a_underflow;
    logic [1:0]  a_det_level;
    logic [31:0] a_sample_cnt, a_sym_err_cnt, a_bit_err_cnt;

    logic        b_start = 0, b_wr_valid = 0, b_rd_valid = 0;
    logic [1:0]  b_wr_level = 0;
    logic [15:0] b_rd_voltage = 0;
    logic        b_det_valid, b_busy, b_done, b_overflow, b_underflow;
    logic [1:0]  b_det_level;
    logic [3:0]  b_sample_cnt, b_sym_err_cnt, b_bit_err_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [1:0] qa_lvl[$], qb_lvl[$];
    int         qa_cyc[$], qb_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vth_level_detector #(.VW(16), .CNT_W(32), .DEPTH(4), .N_SAMPLES(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .thr0(thr0), .thr1(thr1), .thr2(thr2),
        .wr_valid(a_wr_valid), .wr_level(a_wr_level), .rd_valid(a_rd_valid), .rd_voltage(a_rd_voltage),
        .det_valid(a_det_valid), .det_level(a_det_level), .sample_cnt(a_sample_cnt),
        .sym_err_cnt(a_sym_err_cnt), .bit_err_cnt(a_bit_err_cnt), .busy(a_busy), .done(a_done),
        .overflow(a_overflow), .underflow(a_underflow));

    vth_level_detector #(.VW(16), .CNT_W(4), .DEPTH(16), .N_SAMPLES(1000)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .thr0(thr0), .thr1(thr1), .thr2(thr2),
        .wr_valid(b_wr_valid), .wr_level(b_wr_level), .rd_valid(b_rd_valid), .rd_voltage(b_rd_voltage),
        .det_valid(b_det_valid), .det_level(b_det_level), .sample_cnt(b_sample_cnt),
        .sym_err_cnt(b_sym_err_cnt), .bit_err_cnt(b_bit_err_cnt), .busy(b_busy), .done(b_done),
        .overflow(b_overflow), .underflow(b_underflow));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every det_valid pulse must match the oldest expected entry, in level and arrival cycle.
    always @(negedge clk) begin
        if (a_det_valid) begin
            if (qa_lvl.size() == 0) chk("a_unexpected_det", 1, 0);
            else begin
                chk("a_det_level", a_det_level, qa_lvl.pop_front());
                chk("a_det_latency", cyc, qa_cyc.pop_front());
            end
        end
        if (b_det_valid) begin
            if (qb_lvl.size() == 0) chk("b_unexpected_det", 1, 0);
            else begin
                chk("b_det_level", b_det_level, qb_lvl.pop_front());
                chk("b_det_latency", cyc, qb_cyc.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int u);
        if (u == 0) a_start = 1; else b_start = 1;
        tick();
        a_start = 0; b_start = 0;
    endtask

    task automatic wr(input int u, input logic [1:0] lvl);
        if (u == 0) begin a_wr_valid = 1; a_wr_level = lvl; end
        else        begin b_wr_valid = 1; b_wr_level = lvl; end
        tick();
        a_wr_valid = 0; b_wr_valid = 0;
    endtask

    task automatic rd(input int u, input logic [15:0] v, input logic [1:0] exp, input bit expect_det);
        if (u == 0) begin
            a_rd_valid = 1; a_rd_voltage = v;
            if (expect_det) begin qa_lvl.push_back(exp); qa_cyc.push_back(cyc + 1); end
        end else begin
            b_rd_valid = 1; b_rd_voltage = v;
            if (expect_det) begin qb_lvl.push_back(exp); qb_cyc.push_back(cyc + 1); end
        end
        tick();
        a_rd_valid = 0; b_rd_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] lvl_v[4];
    logic [15:0] t1_v[7];
    logic [1:0]  t1_e[7];
    logic [1:0]  t4_l[5];

    initial begin
        lvl_v = '{16'd500, 16'd1500, 16'd2500, 16'd3500};
        t1_v  = '{16'd999, 16'd1000, 16'd1999, 16'd2000, 16'd2999, 16'd3000, 16'd65535};
        t1_e  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        t4_l  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};

        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_det_valid", a_det_valid, 0);
        chk("rst_sample_cnt", a_sample_cnt, 0);
        chk("rst_flags", {a_overflow, a_underflow}, 0);

        // Error counting under the Gray map
        start_run(0);
        chk("start_busy", a_busy, 1);
        for (int i = 0; i < 4; i++) wr(0, 2'(i));
        for (int i = 0; i < 4; i++) rd(0, lvl_v[i], 2'(i), 1);
        chk("match_sym", a_sym_err_cnt, 0);
        chk("match_bit", a_bit_err_cnt, 0);
        wr(0, 2'd0); rd(0, 16'd3500, 2'd3, 1);
        chk("ref0_det3_sym", a_sym_err_cnt, 1);
        chk("ref0_det3_bit", a_bit_err_cnt, 1);
        wr(0, 2'd0); rd(0, 16'd2500, 2'd2, 1);
        chk("ref0_det2_sym", a_sym_err_cnt, 2);
        chk("ref0_det2_bit", a_bit_err_cnt, 3);
        chk("err_sample_cnt", a_sample_cnt, 6);

        // Threshold boundaries; FIFO is empty so these are uncounted underflow reads
        for (int i = 0; i < 7; i++) rd(0, t1_v[i], t1_e[i], 1);
        tick();
        chk("bnd_underflow", a_underflow, 1);
        chk("bnd_sample_cnt", a_sample_cnt, 6);

        // Asynchronous reset mid-run
        #2 reset = 1;
        #1;
        chk("arst_sample_cnt", a_sample_cnt, 0);
        chk("arst_err_cnts", a_sym_err_cnt + a_bit_err_cnt, 0);
        chk("arst_busy_underflow", {a_busy, a_underflow}, 0);
        tick();
        reset = 0;
        tick();
        wr(0, 2'd1);
        rd(0, 16'd1500, 2'd1, 0);
        tick();
        chk("idle_no_run", {a_busy, a_done}, 0);
        chk("idle_sample_cnt", a_sample_cnt, 0);

        // FIFO depth limits
        start_run(0);
        for (int i = 0; i < 5; i++) wr(0, t4_l[i]);
        chk("ovf_set", a_overflow, 1);
        for (int i = 0; i < 4; i++) rd(0, lvl_v[t4_l[i]], t4_l[i], 1);
        chk("fifo_order_sym", a_sym_err_cnt, 0);
        chk("fifo_sample_cnt", a_sample_cnt, 4);
        chk("fifo_no_underflow", a_underflow, 0);
        rd(0, 16'd2500, 2'd2, 1);
        chk("udf_set", a_underflow, 1);
        chk("udf_sample_cnt", a_sample_cnt, 4);

        // Run end at N_SAMPLES
        for (int i = 0; i < 4; i++) begin
            wr(0, 2'(i));
            rd(0, lvl_v[i], 2'(i), 1);
            if (i == 2) chk("pre_done_busy", {a_busy, a_done}, 2'b10);
        end
        chk("done_sample_cnt", a_sample_cnt, 8);
        chk("done_flags", {a_busy, a_done}, 2'b01);
        wr(0, 2'd0);
        rd(0, 16'd500, 2'd0, 0);
        tick();
        chk("frozen_sample_cnt", a_sample_cnt, 8);
        start_run(0);
        chk("restart_cnt", a_sample_cnt + a_sym_err_cnt + a_bit_err_cnt, 0);
        chk("restart_flags", {a_busy, a_done, a_overflow, a_underflow}, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            wr(0, 2'(i % 4));
            rd(0, lvl_v[i % 4], 2'(i % 4), 1);
        end
        chk("rerun_done", {a_done, 32'(a_sample_cnt)}, {1'b1, 32'd8});
        chk("rerun_sym", a_sym_err_cnt, 0);

        // Counter saturation on a 4-bit unit
        start_run(1);
        for (int i = 0; i < 20; i++) begin
            wr(1, 2'd0);
            rd(1, 16'd2500, 2'd2, 1);
        end
        tick();
        chk("sat_sym", b_sym_err_cnt, 15);
        chk("sat_bit", b_bit_err_cnt, 15);
        chk("sat_sample", b_sample_cnt, 15);
        chk("sat_still_busy", {b_busy, b_done}, 2'b10);

        repeat (3) tick();
        chk("scoreboard_drained", qa_lvl.size() + qb_lvl.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
